reg_wr_arbiter: RTL and testbench
=================================

Name: reg_wr_arbiter

Overview:
- Shares one bank of NREG enable-flop registers (WIDTH bits each) among NREQ write requesters.
- Each cycle, selects at most one requester, by round-robin or by a bounded lock.
- Drives the bank with a registered one-hot write-enable vector (one bit per register's enable input) and a registered shared data bus.
- Sits between requester logic and the register bank; the bank itself is external.

Parameters:
- NREQ, 4, number of requesters
- NREG, 8, number of registers in the bank
- AW, 3, address width per requester; NREG ≤ 2**AW
- WIDTH, 8, data width per register
- MAX_HOLD, 4, maximum consecutive grants one requester may keep via lock (≥1)

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- req  input  NREQ  write request, bit i = requester i
- lock  input  NREQ  request to keep the grant next cycle, bit i = requester i
- addr  input  NREQ*AW  target register; requester i uses bits [i*AW +: AW]
- wdata  input  NREQ*WIDTH  write data; requester i uses bits [i*WIDTH +: WIDTH]
- gnt  output  NREQ  combinational one-hot grant; write accepted in any cycle where req[i]&gnt[i]
- reg_en  output  NREG  registered one-hot write enables to the bank
- reg_d  output  WIDTH  registered data to the bank
- busy  output  1  registered; high while in LOCK state
- addr_err  output  1  registered one-cycle pulse: accepted write had addr ≥ NREG

Behaviour:
- Reset (clk edge with reset=1):
  - rr_ptr=0, state=IDLE, hold_cnt=0.
  - reg_en=0, reg_d=0, busy=0, addr_err=0.
  - gnt is forced to 0 during any cycle where reset=1.
- gnt is at most one-hot. gnt[i]=1 only when req[i]=1. If req=0, then gnt=0.
- IDLE state:
  - Grant the first requester with req set, searching rr_ptr, rr_ptr+1, … modulo NREQ.
  - On acceptance of requester i: rr_ptr←(i+1) mod NREQ.
  - If lock[i]=1 and MAX_HOLD>1: state←LOCK, owner←i, hold_cnt←1. Otherwise stay IDLE.
- LOCK state:
  - gnt=onehot(owner) if req[owner]=1, regardless of other requesters.
  - On acceptance: hold_cnt←hold_cnt+1.
  - If lock[owner]=1 and hold_cnt+1 < MAX_HOLD: stay in LOCK. Otherwise return to IDLE.
  - If req[owner]=0: gnt=0 this cycle, state←IDLE; no other requester is granted this cycle.
  - After a forced release at MAX_HOLD, rr_ptr already points past owner, so other requesters get priority.
- Write path, with 1-cycle latency:
  - If a write is accepted in cycle t: in cycle t+1, reg_en=onehot(addr) and reg_d=wdata of the winner.
  - If no write is accepted in cycle t: in cycle t+1, reg_en=0 and reg_d holds its previous value.
- Out-of-range address (addr ≥ NREG):
  - The write is still accepted and rr_ptr still advances.
  - reg_en=0 in t+1 and addr_err=1 in t+1.
- busy reflects state registered: 1 exactly in cycles where state=LOCK.
- Back-to-back writes from different requesters in consecutive cycles give consecutive single-cycle reg_en pulses.
- lock with req=0 is ignored. lock of a non-owner is ignored.
- Reset mid-LOCK: next cycle is IDLE with rr_ptr=0. A write accepted in the reset cycle is dropped (reg_en=0).
- NREQ=1 is legal: that requester is always granted when req=1; rr_ptr stays 0.

Optional Feature:
- Macro: ARB_FIXED_PRIORITY_EN.
- Defined:
  - IDLE-state selection is fixed priority: lowest index wins.
  - rr_ptr is not implemented.
  - After a MAX_HOLD forced release, the released owner is masked out for exactly one cycle, so lower-priority requesters cannot be starved by relocking.
  - LOCK behaviour is otherwise unchanged.
- Undefined: round-robin selection as above.

Test Plan:
- Reset: assert reset with req=4'b1111 for 2 cycles → gnt=0, reg_en=0, reg_d=0, busy=0. After release, first grant goes to requester 0.
- Round-robin: req=4'b1111 held, no lock, addr i=i, wdata i=8'hA0+i, for 4 cycles → gnt sequence 0,1,2,3. reg_en one cycle later is 8'h01,02,04,08 with reg_d A0,A1,A2,A3.
- Lock and hold limit: requester 2 holds req and lock, requester 0 requests, MAX_HOLD=4 → gnt[2] for 4 consecutive cycles, busy=1 during LOCK. Cycle 5 grants requester 0 (rr_ptr=3 wraps to 0).
- Owner drop: requester 1 locks, deasserts req in its 2nd cycle → that cycle gnt=0, state returns to IDLE. Next cycle grants the next pending requester per rr_ptr.
- Bad address: NREG=6, requester 3 writes addr=7, wdata=8'h55 → gnt[3]=1, next cycle reg_en=0 and addr_err=1 for one cycle, reg_d=8'h55.
- Reset mid-lock: reset in the 2nd LOCK cycle → next cycle busy=0, reg_en=0. With req=4'b1010, the next grant is requester 1.

Source files
------------

// File: rtl/reg_wr_arbiter.sv
// reg_wr_arbiter
//   Lets NREQ write requesters share one external bank of NREG enable-flop
//   registers. At most one requester is granted each cycle, either by
//   round-robin or by a bounded lock of up to MAX_HOLD consecutive grants.
//   The winner's write reaches the bank one cycle later as a registered
//   one-hot enable vector plus a registered shared data bus.
//
// Ports
//   clk      : clock; all state updates on the rising edge
//   reset    : synchronous, active-high reset
//   req      : write request per requester
//   lock     : request to keep the grant next cycle, per requester
//   addr     : target register, requester i at [i*AW +: AW]
//   wdata    : write data, requester i at [i*WIDTH +: WIDTH]
//   gnt      : combinational one-hot grant (write accepted when req&gnt)
//   reg_en   : registered one-hot write enables to the bank
//   reg_d    : registered write data to the bank
//   busy     : registered, high while the arbiter is in LOCK
//   addr_err : registered pulse, the accepted write had addr >= NREG
//
// Build option
//   ARB_FIXED_PRIORITY_EN : IDLE selection becomes fixed priority (lowest
//   index wins), no round-robin pointer; an owner released by the hold limit
//   is masked out of selection for one cycle.

module reg_wr_arbiter #(
  parameter int NREQ     = 4,
  parameter int NREG     = 8,
  parameter int AW       = 3,
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ-1:0]       lock,
  input  logic [NREQ*AW-1:0]    addr,
  input  logic [NREQ*WIDTH-1:0] wdata,
  output logic [NREQ-1:0]       gnt,
  output logic [NREG-1:0]       reg_en,
  output logic [WIDTH-1:0]      reg_d,
  output logic                  busy,
  output logic                  addr_err
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int HW = $clog2(MAX_HOLD + 1);

  typedef enum logic [0:0] {IDLE = 1'b0, LOCK = 1'b1} state_t;

  state_t          state_r, state_s;
  logic [PW-1:0]   owner_r, owner_s;
  logic [HW-1:0]   hold_cnt_r, hold_cnt_s;
`ifdef ARB_FIXED_PRIORITY_EN
  logic [NREQ-1:0] mask_r, mask_s;
`else
  logic [PW-1:0]   rr_ptr_r, rr_ptr_s;
`endif

  logic [NREQ-1:0]  cand_s;
  logic [NREQ-1:0]  gnt_s;
  logic             accept_s;
  logic [PW-1:0]    win_s;
  logic [AW-1:0]    sel_addr_s;
  logic [WIDTH-1:0] sel_data_s;
  logic             sel_lock_s;
  logic             in_range_s;
  logic [NREG-1:0]  en_onehot_s;

  // IDLE-state candidate: first requester found from the search start
  always_comb begin
    logic found;
    int   j;
    cand_s = '0;
    found  = 1'b0;
    j      = 0;
    for (int k = 0; k < NREQ; k++) begin
`ifdef ARB_FIXED_PRIORITY_EN
      j = k;
      cand_s[j] = ~found & req[j] & ~mask_r[j];
      found     = found | (req[j] & ~mask_r[j]);
`else
      j = (int'(rr_ptr_r) + k) % NREQ;
      cand_s[j] = ~found & req[j];
      found     = found | req[j];
`endif
    end
  end

  // Grant: nothing in reset, owner only in LOCK, candidate in IDLE
  always_comb begin
    gnt_s = '0;
    if (reset) begin
      gnt_s = '0;
    end else if (state_r == LOCK) begin
      gnt_s[owner_r] = req[owner_r];
    end else begin
      gnt_s = cand_s;
    end
  end

  assign gnt      = gnt_s;
  assign accept_s = |(req & gnt_s);

  // Winner mux: AND-OR over the one-hot grant
  always_comb begin
    win_s      = '0;
    sel_addr_s = '0;
    sel_data_s = '0;
    sel_lock_s = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      win_s      = win_s | (gnt_s[i] ? PW'(i) : '0);
      sel_addr_s = sel_addr_s | ({AW{gnt_s[i]}} & addr[i*AW +: AW]);
      sel_data_s = sel_data_s | ({WIDTH{gnt_s[i]}} & wdata[i*WIDTH +: WIDTH]);
      sel_lock_s = sel_lock_s | (gnt_s[i] & lock[i]);
    end
  end

  // Address decode into a one-hot enable; out-of-range decodes to zero
  always_comb begin
    in_range_s  = (int'(sel_addr_s) < NREG);
    en_onehot_s = '0;
    for (int r = 0; r < NREG; r++) begin
      en_onehot_s[r] = (int'(sel_addr_s) == r);
    end
  end

  // Next-state logic for the IDLE/LOCK machine and its bookkeeping
  always_comb begin
    state_s    = state_r;
    owner_s    = owner_r;
    hold_cnt_s = hold_cnt_r;
`ifdef ARB_FIXED_PRIORITY_EN
    mask_s     = '0;
`else
    rr_ptr_s   = rr_ptr_r;
`endif
    case (state_r)
      IDLE: begin
        if (accept_s) begin
`ifndef ARB_FIXED_PRIORITY_EN
          rr_ptr_s = PW'((int'(win_s) + 1) % NREQ);
`endif
          if (sel_lock_s && (MAX_HOLD > 1)) begin
            state_s    = LOCK;
            owner_s    = win_s;
            hold_cnt_s = HW'(1);
          end else begin
            state_s    = IDLE;
          end
        end else begin
          state_s = IDLE;
        end
      end
      LOCK: begin
        if (accept_s) begin
          // hold_cnt counts grants already given in this lock sequence
          if (sel_lock_s && ((int'(hold_cnt_r) + 1) < MAX_HOLD)) begin
            state_s    = LOCK;
            hold_cnt_s = hold_cnt_r + HW'(1);
          end else begin
            state_s    = IDLE;
            hold_cnt_s = '0;
`ifdef ARB_FIXED_PRIORITY_EN
            // limit-forced release: keep the old owner out for one cycle
            if ((int'(hold_cnt_r) + 1) >= MAX_HOLD) begin
              mask_s[owner_r] = 1'b1;
            end else begin
              mask_s = '0;
            end
`endif
          end
        end else begin
          // owner dropped its request: release without granting anyone
          state_s    = IDLE;
          hold_cnt_s = '0;
        end
      end
      default: begin
        state_s    = IDLE;
        hold_cnt_s = '0;
      end
    endcase
  end

  // State and registered bank-side outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      owner_r    <= '0;
      hold_cnt_r <= '0;
`ifdef ARB_FIXED_PRIORITY_EN
      mask_r     <= '0;
`else
      rr_ptr_r   <= '0;
`endif
      reg_en     <= '0;
      reg_d      <= '0;
      busy       <= 1'b0;
      addr_err   <= 1'b0;
    end else begin
      state_r    <= state_s;
      owner_r    <= owner_s;
      hold_cnt_r <= hold_cnt_s;
`ifdef ARB_FIXED_PRIORITY_EN
      mask_r     <= mask_s;
`else
      rr_ptr_r   <= rr_ptr_s;
`endif
      reg_en     <= (accept_s && in_range_s) ? en_onehot_s : '0;
      if (accept_s) begin
        reg_d <= sel_data_s;
      end
      busy       <= (state_s == LOCK);
      addr_err   <= accept_s & ~in_range_s;
    end
  end

endmodule

// File: tb/tb_reg_wr_arbiter.sv
// Self-checking bench for reg_wr_arbiter (NREQ=4, NREG=6, AW=3, WIDTH=8,
// MAX_HOLD=4). A behavioural model predicts gnt in the same cycle and pushes
// the expected bank-side outputs to a scoreboard queue that is popped and
// compared one clock later.

module tb_reg_wr_arbiter;

  localparam int NREQ     = 4;
  localparam int NREG     = 6;
  localparam int AW       = 3;
  localparam int WIDTH    = 8;
  localparam int MAX_HOLD = 4;

  logic                  clk;
  logic                  reset;
  logic [NREQ-1:0]       req;
  logic [NREQ-1:0]       lock;
  logic [NREQ*AW-1:0]    addr;
  logic [NREQ*WIDTH-1:0] wdata;
  logic [NREQ-1:0]       gnt;
  logic [NREG-1:0]       reg_en;
  logic [WIDTH-1:0]      reg_d;
  logic                  busy;
  logic                  addr_err;

  int total = 0;
  int bad   = 0;

  // model state
  int              m_state = 0;
  int              m_owner = 0;
  int              m_hold  = 0;
  int              m_ptr   = 0;
  logic [7:0]      m_regd  = 8'h00;
  logic [3:0]      m_mask  = 4'h0;

  // scoreboard entry: {reg_en[5:0], reg_d[7:0], addr_err, busy}
  logic [15:0] sb_q[$];

  reg_wr_arbiter #(
    .NREQ(NREQ), .NREG(NREG), .AW(AW), .WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .lock(lock), .addr(addr),
    .wdata(wdata), .gnt(gnt), .reg_en(reg_en), .reg_d(reg_d),
    .busy(busy), .addr_err(addr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // One clock of stimulus: check gnt mid-cycle, then the registered outputs
  task automatic drive(input logic r, input logic [3:0] rq, input logic [3:0] lk,
                       input logic [11:0] ad, input logic [31:0] wd);
    logic [3:0]  eg;
    logic [5:0]  een;
    logic        eerr;
    logic [15:0] ent;
    int          w;
    int          a;
    @(negedge clk);
    reset = r; req = rq; lock = lk; addr = ad; wdata = wd;
    #1;
    eg = 4'h0;
    w  = -1;
    if (!r) begin
      if (m_state == 1) begin
        if (rq[m_owner]) w = m_owner;
      end else begin
        for (int k = 0; k < 4; k++) begin
`ifdef ARB_FIXED_PRIORITY_EN
          if (w < 0 && rq[k] && !m_mask[k]) w = k;
`else
          if (w < 0 && rq[(m_ptr + k) % 4]) w = (m_ptr + k) % 4;
`endif
        end
      end
    end
    if (w >= 0) eg[w] = 1'b1;
    check_val("gnt", {28'h0, gnt}, {28'h0, eg});

    een  = 6'h00;
    eerr = 1'b0;
    if (w >= 0) begin
      a = int'(ad[w*3 +: 3]);
      if (a < NREG) een[a] = 1'b1;
      else eerr = 1'b1;
      m_regd = wd[w*8 +: 8];
    end

    m_mask = 4'h0;
    if (r) begin
      m_state = 0; m_ptr = 0; m_hold = 0; m_regd = 8'h00; een = 6'h00; eerr = 1'b0;
    end else if (w >= 0) begin
      if (m_state == 0) begin
        m_ptr = (w + 1) % 4;
        if (lk[w] && MAX_HOLD > 1) begin
          m_state = 1; m_owner = w; m_hold = 1;
        end
      end else begin
        m_hold++;
        if (!(lk[w] && m_hold < MAX_HOLD)) begin
          if (m_hold >= MAX_HOLD) m_mask[m_owner] = 1'b1;
          m_state = 0;
        end
      end
    end else if (m_state == 1) begin
      m_state = 0;
    end
    sb_q.push_back({een, m_regd, eerr, (m_state == 1)});

    @(posedge clk);
    #1;
    ent = sb_q.pop_front();
    check_val("reg_en",   {26'h0, reg_en}, {26'h0, ent[15:10]});
    check_val("reg_d",    {24'h0, reg_d},  {24'h0, ent[9:2]});
    check_val("addr_err", {31'h0, addr_err}, {31'h0, ent[1]});
    check_val("busy",     {31'h0, busy},   {31'h0, ent[0]});
  endtask

  // addr field {a3,a2,a1,a0} and data {d3,d2,d1,d0}
  localparam logic [11:0] ADDR_ID = {3'd3, 3'd2, 3'd1, 3'd0};
  localparam logic [31:0] DATA_A  = 32'hA3A2A1A0;

  initial begin
    reset = 1'b1; req = 4'h0; lock = 4'h0; addr = 12'h000; wdata = 32'h0;

    // reset with all requests pending
    drive(1'b1, 4'b1111, 4'b0000, ADDR_ID, DATA_A);
    drive(1'b1, 4'b1111, 4'b0000, ADDR_ID, DATA_A);

    // round-robin, first grant after reset goes to requester 0
    for (int c = 0; c < 5; c++) drive(1'b0, 4'b1111, 4'b0000, ADDR_ID, DATA_A);
    drive(1'b0, 4'b0000, 4'b0000, ADDR_ID, DATA_A);

    // lock with hold limit: requester 2 locks, requester 0 waits
    drive(1'b0, 4'b0010, 4'b0000, ADDR_ID, DATA_A);
    for (int c = 0; c < 5; c++) drive(1'b0, 4'b0101, 4'b0100, ADDR_ID, DATA_A);
    drive(1'b0, 4'b0000, 4'b0000, ADDR_ID, DATA_A);

    // owner drop: requester 1 locks then deasserts req
    drive(1'b0, 4'b0010, 4'b0010, ADDR_ID, DATA_A);
    drive(1'b0, 4'b1001, 4'b0000, ADDR_ID, DATA_A);
    drive(1'b0, 4'b1001, 4'b0000, ADDR_ID, DATA_A);
    drive(1'b0, 4'b0000, 4'b0000, ADDR_ID, DATA_A);

    // out-of-range addresses 7 and 6, then the last in-range address 5
    drive(1'b0, 4'b1000, 4'b0000, {3'd7, 3'd0, 3'd0, 3'd0}, 32'h55000000);
    drive(1'b0, 4'b1000, 4'b0000, {3'd6, 3'd0, 3'd0, 3'd0}, 32'h66000000);
    drive(1'b0, 4'b1000, 4'b0000, {3'd5, 3'd0, 3'd0, 3'd0}, 32'h77000000);
    drive(1'b0, 4'b0000, 4'b0000, ADDR_ID, DATA_A);

    // reset in the 2nd LOCK cycle, then req=1010
    drive(1'b0, 4'b0100, 4'b0100, ADDR_ID, DATA_A);
    drive(1'b1, 4'b0100, 4'b0100, ADDR_ID, DATA_A);
    drive(1'b0, 4'b1010, 4'b0000, ADDR_ID, DATA_A);

    // random traffic
    for (int c = 0; c < 300; c++) begin
      drive(($urandom_range(0, 49) == 0) ? 1'b1 : 1'b0,
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            12'($urandom), $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
